// File: rtl/seg_scan_reader.sv
// Recovers the hex digits shown on a multiplexed active-low 7-segment bus and
// emits each completed frame of NUM_DIGITS nibbles over a valid/ready handshake.
module seg_scan_reader #(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [7:0]              i_seg,
  input  logic [NUM_DIGITS-1:0]   i_dig_sel,
  input  logic                    i_ready,
  output logic [4*NUM_DIGITS-1:0] o_value,
  output logic [NUM_DIGITS-1:0]   o_err,
  output logic                    o_valid,
  output logic                    o_overrun,
  output logic [1:0]              o_dbg_state,
  output logic [NUM_DIGITS-1:0]   o_dbg_mask
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Handshake: a frame transfers on a rising edge where o_valid && i_ready;
  // o_value/o_err stay frozen while o_valid is high and not yet accepted.

  state_t                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [6:0]              pat_q, pat_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] stage_val_q, stage_val_d;
  logic [NUM_DIGITS-1:0]   stage_err_q, stage_err_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  logic       one_hot;
  logic       same_sel;
  logic       same_pat;
  logic       capture;
  logic       frame_done;
  logic [4:0] dec;

  // Returns {illegal, nibble}; illegal patterns decode to nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40:   decode = 5'h00;
      7'h79:   decode = 5'h01;
      7'h24:   decode = 5'h02;
      7'h30:   decode = 5'h03;
      7'h19:   decode = 5'h04;
      7'h12:   decode = 5'h05;
      7'h02:   decode = 5'h06;
      7'h78:   decode = 5'h07;
      7'h00:   decode = 5'h08;
      7'h10:   decode = 5'h09;
      7'h08:   decode = 5'h0A;
      7'h03:   decode = 5'h0B;
      7'h46:   decode = 5'h0C;
      7'h21:   decode = 5'h0D;
      7'h06:   decode = 5'h0E;
      7'h0E:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    one_hot  = $onehot(i_dig_sel);
    same_sel = (i_dig_sel == sel_q);
    same_pat = (i_seg[6:0] == pat_q);
    dec      = decode(pat_q);

    state_d     = state_q;
    sel_d       = sel_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;

    // A change seen in SETTLE or HOLD is re-evaluated as IDLE in the same cycle.
    case (state_q)
      IDLE: begin
        if (one_hot) begin
          sel_d   = i_dig_sel;
          pat_d   = i_seg[6:0];
          cnt_d   = CW'(1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (same_sel && same_pat) begin
          if (cnt_q == CW'(STABLE_CYCLES)) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (one_hot) begin
          sel_d   = i_dig_sel;
          pat_d   = i_seg[6:0];
          cnt_d   = CW'(1);
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (!same_sel) begin
          if (one_hot) begin
            sel_d   = i_dig_sel;
            pat_d   = i_seg[6:0];
            cnt_d   = CW'(1);
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    frame_done  = &mask_q;
    mask_d      = frame_done ? '0 : mask_q;
    stage_val_d = stage_val_q;
    stage_err_d = stage_err_q;
    if (capture) begin
      mask_d = mask_d | sel_q;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (sel_q[k]) begin
          stage_val_d[4*k +: 4] = dec[3:0];
          stage_err_d[k]        = dec[4];
        end
      end
    end

    value_d   = value_q;
    err_d     = err_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (frame_done) begin
      if (!valid_q || i_ready) begin
        value_d = stage_val_q;
        err_d   = stage_err_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      pat_q       <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      stage_val_q <= '0;
      stage_err_q <= '0;
      value_q     <= '0;
      err_q       <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      stage_val_q <= stage_val_d;
      stage_err_q <= stage_err_d;
      value_q     <= value_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_value     = value_q;
  assign o_err       = err_q;
  assign o_valid     = valid_q;
  assign o_overrun   = overrun_q;
  assign o_dbg_state = state_q;
  assign o_dbg_mask  = mask_q;

endmodule
